// File: rtl/execute_stage_pkg.sv
// Shared Y86 definitions for the execute stage: icodes, ALU ops, conditions and the E->M register layout.
package execute_stage_pkg;

    localparam int D_WORD = 32;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IRMMOVL = 4'h4;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHL  = 4'hA;
    localparam logic [3:0] IPOPL   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic              valid;
        logic [3:0]        icode;
        logic              cnd;
        logic [D_WORD-1:0] val_e;
        logic [D_WORD-1:0] val_a;
        logic [3:0]        dst_e;
        logic [3:0]        dst_m;
        logic              ins_err;
    } em_reg_t;

    localparam em_reg_t EM_BUBBLE = '{valid: 1'b0, icode: INOP, cnd: 1'b0,
                                      val_e: '0, val_a: '0, dst_e: RNONE,
                                      dst_m: RNONE, ins_err: 1'b0};

    function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                       input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (ifun)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | zf;
            C_L:     cond_eval = lt;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = ~zf;
            C_GE:    cond_eval = ~lt;
            C_G:     cond_eval = ~lt & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute inputs and E->M register outputs of the execute stage, with both ends as modports.
interface execute_stage_if #(parameter int WIDTH = 32);
    logic             e_valid;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [WIDTH-1:0] e_valC;
    logic [WIDTH-1:0] e_valA;
    logic [WIDTH-1:0] e_valB;
    logic [3:0]       e_dstE;
    logic [3:0]       e_dstM;

    logic             m_valid;
    logic [3:0]       m_icode;
    logic             m_Cnd;
    logic [WIDTH-1:0] m_valE;
    logic [WIDTH-1:0] m_valA;
    logic [3:0]       m_dstE;
    logic [3:0]       m_dstM;
    logic             m_ins_err;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    modport master (
        output e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
        input  m_valid, m_icode, m_Cnd, m_valE, m_valA, m_dstE, m_dstM, m_ins_err,
        input  cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
        output m_valid, m_icode, m_Cnd, m_valE, m_valA, m_dstE, m_dstM, m_ins_err,
        output cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational Y86 ALU: result = B op A, with zero/sign/overflow flags.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    input  logic [3:0]       alu_fn_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);
    localparam int MSB = WIDTH - 1;

    always_comb begin
        result_o = '0;
        of_o     = 1'b0;
        case (alu_fn_i)
            ALUADD: begin
                result_o = alu_b_i + alu_a_i;
                of_o     = (alu_a_i[MSB] == alu_b_i[MSB]) && (result_o[MSB] != alu_a_i[MSB]);
            end
            ALUSUB: begin
                result_o = alu_b_i - alu_a_i;
                of_o     = (alu_a_i[MSB] != alu_b_i[MSB]) && (result_o[MSB] != alu_b_i[MSB]);
            end
            ALUAND:  result_o = alu_b_i & alu_a_i;
            ALUXOR:  result_o = alu_b_i ^ alu_a_i;
            default: result_o = '0;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = result_o[MSB];
endmodule

// File: rtl/execute_stage.sv
// Y86 execute stage: ALU, condition codes, Cnd evaluation and the E->M pipeline register.
// Optional macro EXEC_CC_GATE_EN adds a cc_block input that suppresses CC writes.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH      = D_WORD,
    parameter int STACK_STEP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic e_stall,
    input  logic e_bubble,
`ifdef EXEC_CC_GATE_EN
    input  logic cc_block,
`endif
    execute_stage_if.slave bus
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_fn;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             ins_err;
    logic             cnd;
    logic             cc_we;
    logic             zf_q, sf_q, of_q;
    em_reg_t          em_d, em_q;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (bus.e_icode)
            IRRMOVL, IOPL:             alu_a = bus.e_valA;
            IIRMOVL, IRMMOVL, IMRMOVL: alu_a = bus.e_valC;
            ICALL, IPUSHL:             alu_a = '0 - WIDTH'(STACK_STEP);
            IRET, IPOPL:               alu_a = WIDTH'(STACK_STEP);
            default:                   alu_a = '0;
        endcase
        case (bus.e_icode)
            IRMMOVL, IMRMOVL, IOPL, ICALL, IPUSHL, IRET, IPOPL: alu_b = bus.e_valB;
            default:                                            alu_b = '0;
        endcase
    end

    assign alu_fn = (bus.e_icode == IOPL) ? bus.e_ifun : ALUADD;

    execute_stage_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alu_fn_i (alu_fn),
        .result_o (alu_res),
        .zf_o     (alu_zf),
        .sf_o     (alu_sf),
        .of_o     (alu_of)
    );

    assign ins_err = (bus.e_icode > IPOPL);
    // Cnd reads the CC as it stands before this instruction's own update.
    assign cnd     = cond_eval(bus.e_ifun, zf_q, sf_q, of_q);

`ifdef EXEC_CC_GATE_EN
    assign cc_we = bus.e_valid && (bus.e_icode == IOPL) && !e_stall && !e_bubble && !cc_block;
`else
    assign cc_we = bus.e_valid && (bus.e_icode == IOPL) && !e_stall && !e_bubble;
`endif

    always_comb begin
        em_d = EM_BUBBLE;
        if (bus.e_valid) begin
            em_d.valid   = 1'b1;
            em_d.icode   = bus.e_icode;
            em_d.cnd     = cnd;
            em_d.val_e   = ins_err ? '0 : alu_res;
            em_d.val_a   = bus.e_valA;
            em_d.dst_e   = (bus.e_icode == IRRMOVL && !cnd) ? RNONE : bus.e_dstE;
            em_d.dst_m   = bus.e_dstM;
            em_d.ins_err = ins_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= EM_BUBBLE;
        end else if (e_stall) begin
            em_q <= em_q;
        end else if (e_bubble) begin
            em_q <= EM_BUBBLE;
        end else begin
            em_q <= em_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (cc_we) begin
            zf_q <= alu_zf;
            sf_q <= alu_sf;
            of_q <= alu_of;
        end
    end

    assign bus.m_valid   = em_q.valid;
    assign bus.m_icode   = em_q.icode;
    assign bus.m_Cnd     = em_q.cnd;
    assign bus.m_valE    = em_q.val_e;
    assign bus.m_valA    = em_q.val_a;
    assign bus.m_dstE    = em_q.dst_e;
    assign bus.m_dstM    = em_q.dst_m;
    assign bus.m_ins_err = em_q.ins_err;
    assign bus.cc_zf     = zf_q;
    assign bus.cc_sf     = sf_q;
    assign bus.cc_of     = of_q;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86 execute stage, directly downstream of the register-file/decode stage.
- Consumes decoded icode/ifun, valC and the register-file read data valA/valB.
- Computes valE on the ALU, maintains the condition-code register, evaluates Cnd for jXX/cmovXX, and registers results into the E->M pipeline register.
- Supports stall and bubble control from pipeline control logic.

Parameters:
- WIDTH, 32, data word width (matches D_WORD)
- STACK_STEP, 4, byte adjustment applied to %esp for call/push/ret/pop

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- e_stall  input  1  hold E->M register and CC
- e_bubble  input  1  load NOP into E->M register
- e_valid  input  1  E-stage slot holds a real instruction
- e_icode  input  4  instruction code
- e_ifun  input  4  function code (ALU op or condition)
- e_valC  input  WIDTH  immediate/displacement
- e_valA  input  WIDTH  register-file port A data
- e_valB  input  WIDTH  register-file port B data
- e_dstE  input  4  E destination register
- e_dstM  input  4  M destination register
- m_valid  output  1  registered valid
- m_icode  output  4  registered icode
- m_Cnd  output  1  registered condition result
- m_valE  output  WIDTH  registered ALU result
- m_valA  output  WIDTH  registered valA, pass-through for store/return
- m_dstE  output  4  registered dstE, RNONE if cmov not taken
- m_dstM  output  4  registered dstM
- m_ins_err  output  1  registered invalid-icode flag
- cc_zf, cc_sf, cc_of  output  1 each  current condition codes

Behaviour:
- Reset (async, rst_n low):
  - m_valid=0, m_icode=INOP, m_Cnd=0, m_valE=0, m_valA=0
  - m_dstE=RNONE, m_dstM=RNONE, m_ins_err=0
  - ZF=1, SF=0, OF=0
- ALU operand A:
  - valA for RRMOVL/OPL
  - valC for IRMOVL/RMMOVL/MRMOVL
  - -STACK_STEP for CALL/PUSHL
  - +STACK_STEP for RET/POPL
  - 0 otherwise
- ALU operand B:
  - valB for RMMOVL/MRMOVL/OPL/CALL/PUSHL/RET/POPL
  - 0 otherwise
- ALU function: ifun when icode=OPL, else ADD.
  - ADD(0): B+A
  - SUB(1): B-A
  - AND(2): B&A
  - XOR(3): B^A
  - ifun>3 under OPL: result 0
- Width: result truncated to WIDTH, two's complement.
- Flags:
  - ZF = result==0
  - SF = result MSB
  - OF, ADD: A,B same sign and result sign differs
  - OF, SUB: B,A differ in sign and result sign differs from B
  - OF, logic ops: 0
- CC update: on a clk edge when e_valid & icode==OPL & !e_stall & !e_bubble.
- Cnd: evaluated from current (pre-update) CC.
  - ifun 0: 1 (always)
  - 1 LE: (SF^OF)|ZF
  - 2 L: SF^OF
  - 3 E: ZF
  - 4 NE: !ZF
  - 5 GE: !(SF^OF)
  - 6 G: !(SF^OF)&!ZF
  - ifun>6: 0
- m_dstE: RNONE when icode==RRMOVL & !Cnd, otherwise e_dstE.
- Invalid icode (>0xB): valE=0, CC untouched, m_ins_err=1, otherwise passed through.
- Latency: one cycle from inputs to m_* outputs.
- Priority: reset > e_stall > e_bubble > normal load.
  - e_stall: all m_* and CC hold.
  - e_bubble: m_* take reset values (except CC, which holds).
  - e_valid=0 with neither asserted: loads bubble values.
- Reset mid-operation: immediate return to reset values; no partial CC write.

Optional Feature:
- Macro: EXEC_CC_GATE_EN.
- When defined:
  - Adds input cc_block (1 bit), driven by pipeline control when M or W holds an exception.
  - CC update is additionally gated by !cc_block.
  - m_* outputs are unaffected.
- When undefined: port absent; CC updates per the rule above.

Decomposition:
- Shared package (alongside existing defines):
  - icode constants IHALT..IPOPL
  - ALU function constants ALUADD/ALUSUB/ALUAND/ALUXOR
  - condition constants C_YES..C_G
  - RNONE
  - stage-register struct typedef for E->M
- One natural sub-module: alu (combinational; operands, fn -> result, zf/sf/of). Instantiated once.
- CC register, Cnd logic and pipeline register live in execute_stage.

Test Plan:
- addl, valA=5, valB=3 -> next cycle m_valE=8, ZF=0, SF=0, OF=0.
- subl, valA=valB=0x10 -> m_valE=0, ZF=1.
- Then cmovle (ifun 1), dstE=2 -> m_Cnd=1, m_dstE=2.
- Then cmovg (ifun 6) -> m_Cnd=0, m_dstE=RNONE(F).
- addl, valA=1, valB=0x7FFFFFFF -> m_valE=0x80000000, SF=1, OF=1, ZF=0.
- pushl, valB=0x100 -> m_valE=0xFC; popl, valB=0xFC -> m_valE=0x100; CC unchanged in both.
- Load addl, then assert e_stall 2 cycles with new inputs -> m_* and CC frozen.
- Assert e_bubble with subl on inputs -> m_icode=INOP, m_dstE=F, m_valid=0, CC unchanged.
- e_stall+e_bubble together -> hold.
- Drop rst_n mid-stream -> all outputs and CC at reset values immediately.
- icode=0xC -> m_ins_err=1, m_valE=0.
